// File: rtl/misr_checker_if.sv
// Sample/handshake bundle between a response source and a MISR signature checker.
// Latency: none (wires only).
// Backpressure: none; the checker accepts every in_valid word while it is running.
//
// Signals: start/in_valid/data_in/expected driven by the master (bench or BIST
// controller); busy/done/pass/signature/count driven back by the checker (slave).
interface misr_checker_if #(
   parameter int WIDTH       = 20,
   parameter int NUM_SAMPLES = 10
);
   localparam int CW = $clog2(NUM_SAMPLES + 1);

   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] expected;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;
   logic [CW-1:0]    count;

   modport master (
      output start, in_valid, data_in, expected,
      input  busy, done, pass, signature, count
   );

   modport slave (
      input  start, in_valid, data_in, expected,
      output busy, done, pass, signature, count
   );
endinterface

// File: rtl/misr_checker.sv
// Compacts NUM_SAMPLES accepted words into a MISR and compares the result with a golden signature.
// Latency: done/pass valid 1 cycle after the final accepted sample.
// Backpressure: none; every in_valid word is consumed while busy, ignored otherwise.
//
// Ports: clk, rst (async, active-high) plus bus (slave side of misr_checker_if):
//   start begins a run from IDLE/DONE; in_valid/data_in carry samples; expected is
//   the golden signature; busy/done/pass/signature/count report progress and result.
module misr_checker #(
   parameter int               WIDTH       = 20,
   parameter int               NUM_SAMPLES = 10,
   parameter logic [WIDTH-1:0] POLY        = 20'h00009,
   parameter logic [WIDTH-1:0] SEED        = 20'h00000
) (
   input  logic           clk,
   input  logic           rst,
   misr_checker_if.slave  bus
);
   localparam int          CW   = $clog2(NUM_SAMPLES + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sig_r;
   logic [WIDTH-1:0] sig_next;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;

   // Galois-style MISR step: shift left, fold the bit shifted out back in
   // through the tap mask, then XOR the incoming word over the whole register.
   always_comb begin
      sig_next = {sig_r[WIDTH-2:0], 1'b0} ^ (sig_r[WIDTH-1] ? POLY : '0) ^ bus.data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sig_r  <= SEED;
         cnt_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A word arriving together with start is deliberately dropped:
               // the start cycle only loads the seed.
               if (bus.start) begin
                  state  <= RUN;
                  sig_r  <= SEED;
                  cnt_r  <= '0;
                  busy_r <= 1'b1;
               end
            end
            RUN: begin
               // start is ignored here so a stray pulse cannot truncate a run.
               if (bus.in_valid) begin
                  sig_r <= sig_next;
                  cnt_r <= cnt_r + CW'(1);
                  if (cnt_r == LAST) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     // Golden value is compared against the post-update
                     // signature, so expected must be stable on this cycle.
                     pass_r <= (sig_next == bus.expected);
                  end
               end
            end
            DONE: begin
               if (bus.start) begin
                  state  <= RUN;
                  sig_r  <= SEED;
                  cnt_r  <= '0;
                  busy_r <= 1'b1;
                  done_r <= 1'b0;
                  pass_r <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
               pass_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.signature = sig_r;
   assign bus.count     = cnt_r;
endmodule

// File: tb/tb_misr_checker.sv
// Bench for misr_checker: three instances (1, 2 and 10 samples per run) driven from one stimulus set.
// Latency: results checked on the negedge after done rises.
// Backpressure: not applicable; the bench drives one sample per cycle or idles.
module tb_misr_checker;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [19:0] data_in = '0;
   logic [19:0] expected = '0;
   int          sel = 0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   misr_checker_if #(.WIDTH(20), .NUM_SAMPLES(1))  b1 ();
   misr_checker_if #(.WIDTH(20), .NUM_SAMPLES(2))  b2 ();
   misr_checker_if #(.WIDTH(20), .NUM_SAMPLES(10)) b10 ();

   assign b1.start     = start & (sel == 1);
   assign b1.in_valid  = in_valid & (sel == 1);
   assign b1.data_in   = data_in;
   assign b1.expected  = expected;
   assign b2.start     = start & (sel == 2);
   assign b2.in_valid  = in_valid & (sel == 2);
   assign b2.data_in   = data_in;
   assign b2.expected  = expected;
   assign b10.start    = start & (sel == 10);
   assign b10.in_valid = in_valid & (sel == 10);
   assign b10.data_in  = data_in;
   assign b10.expected = expected;

   misr_checker #(.WIDTH(20), .NUM_SAMPLES(1))  u1  (.clk(clk), .rst(rst), .bus(b1));
   misr_checker #(.WIDTH(20), .NUM_SAMPLES(2))  u2  (.clk(clk), .rst(rst), .bus(b2));
   misr_checker #(.WIDTH(20), .NUM_SAMPLES(10)) u10 (.clk(clk), .rst(rst), .bus(b10));

   typedef struct {
      int          dut;
      logic [19:0] sig;
      logic        pass;
      int          cnt;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int          dut;
      int          n;
      logic [19:0] d0;
      logic [19:0] d1;
      int          gap;
      logic [19:0] golden;
      logic [19:0] exp_sig;
      logic        exp_pass;
   } vec_t;
   vec_t tbl[8];

   function automatic logic [19:0] misr_step(input logic [19:0] s, input logic [19:0] d);
      logic [19:0] r;
      r = {s[18:0], 1'b0};
      if (s[19]) r = r ^ 20'h00009;
      return r ^ d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic sb_check(input int dut, input logic [19:0] sig, input logic pass, input int cnt);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_done: dut %0d raised done, expected nothing", dut);
      end else begin
         e = sb_q.pop_front();
         chk("sb_dut", 32'(dut), 32'(e.dut));
         chk("sb_signature", 32'(sig), 32'(e.sig));
         chk("sb_pass", 32'(pass), 32'(e.pass));
         chk("sb_count", 32'(cnt), 32'(e.cnt));
      end
   endtask

   logic p1 = 1'b0, p2 = 1'b0, p10 = 1'b0;
   always @(negedge clk) begin
      if (b1.done && !p1)   sb_check(1, b1.signature, b1.pass, int'(b1.count));
      if (b2.done && !p2)   sb_check(2, b2.signature, b2.pass, int'(b2.count));
      if (b10.done && !p10) sb_check(10, b10.signature, b10.pass, int'(b10.count));
      p1  <= b1.done;
      p2  <= b2.done;
      p10 <= b10.done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic sample(input logic [19:0] d);
      in_valid = 1'b1;
      data_in  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic push(input int dut, input logic [19:0] sig, input logic pass, input int cnt);
      sb_t e;
      e.dut = dut; e.sig = sig; e.pass = pass; e.cnt = cnt;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic run_vec(input vec_t v);
      sel      = v.dut;
      expected = v.golden;
      pulse_start();
      for (int i = 0; i < v.n; i++) begin
         if (i > 0) begin
            for (int g = 0; g < v.gap; g++) begin
               chk("gap_count", 32'(b2.count), 32'd1);
               start = (g == 1);
               tick();
               start = 1'b0;
            end
         end
         if (i == v.n - 1) push(v.dut, v.exp_sig, v.exp_pass, v.n);
         sample(i == 0 ? v.d0 : v.d1);
      end
      drain();
   endtask

   task automatic run10(input bit good);
      logic [19:0] s;
      logic [19:0] d;
      sel = 10;
      s   = 20'h00000;
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         d = 20'($urandom);
         s = misr_step(s, d);
         if (i == 9) begin
            expected = good ? s : (s ^ 20'h00001);
            push(10, s, good, 10);
         end
         sample(d);
      end
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1, 1, 20'h12345, 20'h00000, 0, 20'h12345, 20'h12345, 1'b1};
      tbl[1] = '{1, 1, 20'hABCDE, 20'h00000, 0, 20'h00000, 20'hABCDE, 1'b0};
      tbl[2] = '{1, 1, 20'hFFFFF, 20'h00000, 0, 20'hFFFFF, 20'hFFFFF, 1'b1};
      tbl[3] = '{2, 2, 20'h80000, 20'h00000, 0, 20'h00009, 20'h00009, 1'b1};
      tbl[4] = '{2, 2, 20'h80000, 20'h00000, 0, 20'h00008, 20'h00009, 1'b0};
      tbl[5] = '{2, 2, 20'h80000, 20'h00000, 3, 20'h00009, 20'h00009, 1'b1};
      tbl[6] = '{2, 2, 20'h00001, 20'h00002, 0, 20'h00000, 20'h00000, 1'b1};
      tbl[7] = '{2, 2, 20'hC0000, 20'h00000, 0, 20'h80009, 20'h80009, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(b10.busy), 32'd0);
      chk("rst_done", 32'(b10.done), 32'd0);
      chk("rst_pass", 32'(b10.pass), 32'd0);
      chk("rst_sig", 32'(b10.signature), 32'd0);
      chk("rst_count", 32'(b10.count), 32'd0);
      chk("rst_done_b2", 32'(b2.done), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Table-driven runs
      for (int t = 0; t < 8; t++) run_vec(tbl[t]);

      // DONE ignores in_valid: dut2 holds 80009 / count 2 / pass 1
      sel = 2;
      in_valid = 1'b1;
      data_in  = 20'h12345;
      tick();
      tick();
      in_valid = 1'b0;
      chk("done_hold_sig", 32'(b2.signature), 32'h80009);
      chk("done_hold_count", 32'(b2.count), 32'd2);
      chk("done_hold_pass", 32'(b2.pass), 32'd1);
      chk("done_hold_done", 32'(b2.done), 32'd1);

      // start with in_valid in DONE: seed only, word dropped
      start    = 1'b1;
      in_valid = 1'b1;
      data_in  = 20'hFFFFF;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("restart_busy", 32'(b2.busy), 32'd1);
      chk("restart_done", 32'(b2.done), 32'd0);
      chk("restart_count", 32'(b2.count), 32'd0);
      chk("restart_sig", 32'(b2.signature), 32'd0);
      chk("restart_pass", 32'(b2.pass), 32'd0);
      expected = 20'h00009;
      push(2, 20'h00009, 1'b1, 2);
      sample(20'h80000);
      sample(20'h00000);
      drain();

      // Reset mid-run on the 10-sample instance
      sel = 10;
      pulse_start();
      for (int i = 0; i < 4; i++) sample(20'($urandom));
      chk("pre_rst_count", 32'(b10.count), 32'd4);
      rst = 1'b1;
      #2;
      chk("midrst_busy", 32'(b10.busy), 32'd0);
      chk("midrst_done", 32'(b10.done), 32'd0);
      chk("midrst_count", 32'(b10.count), 32'd0);
      chk("midrst_sig", 32'(b10.signature), 32'd0);
      rst = 1'b0;
      tick();

      // Clean run after reset, then a mismatching one
      run10(1'b1);
      run10(1'b0);
      run10(1'b1);

      // Restart from DONE with all-zero data
      pulse_start();
      chk("rerun_done_fell", 32'(b10.done), 32'd0);
      chk("rerun_pass_clr", 32'(b10.pass), 32'd0);
      chk("rerun_busy", 32'(b10.busy), 32'd1);
      expected = 20'h00000;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) chk("rerun_pass_mid", 32'(b10.pass), 32'd0);
         if (i == 9) push(10, 20'h00000, 1'b1, 10);
         sample(20'h00000);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/misr_checker.md
Name: misr_checker

Overview:
- Response-side counterpart to the randomized stimulus drivers used on URCPU datapath blocks.
- Compacts a stream of DUT output words into a multiple-input signature register (MISR) over a fixed number of samples.
- At the end of the run, compares the signature against an expected value and flags pass/fail.
- Sits at the output of any 20-bit datapath unit (e.g. not_gate) for self-checking benches and on-chip BIST.

Parameters:
- WIDTH, 20, data and signature width in bits.
- NUM_SAMPLES, 10, number of accepted samples per run (>=1).
- POLY, 20'h00009, feedback taps (x^20+x^3+1); bit i set = XOR into bit i on feedback.
- SEED, 20'h00000, signature value loaded on start and on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a run when in IDLE or DONE.
- in_valid  in  1  data_in is a sample this cycle.
- data_in  in  WIDTH  DUT output word.
- expected  in  WIDTH  golden signature; sampled on the final accepting cycle.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level, not pulse).
- pass  out  1  final signature equals expected; valid only while done=1.
- signature  out  WIDTH  current MISR contents.
- count  out  CW  samples accepted this run; CW = $clog2(NUM_SAMPLES+1).

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, signature=SEED, count=0, busy=0, done=0, pass=0. Reset mid-run aborts the run; no partial result is retained.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: start=1 -> RUN next cycle; signature<=SEED, count<=0. in_valid is ignored.
- RUN, in_valid=1:
  - sig_next = ({signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0)) ^ data_in.
  - signature<=sig_next; count<=count+1.
- RUN, in_valid=0: hold signature and count; gaps of any length are allowed.
- RUN, in_valid=1 with count==NUM_SAMPLES-1 (final sample):
  - state<=DONE; pass<=(sig_next==expected).
  - busy falls and done rises one cycle after the final sample.
- RUN: start is ignored and does not restart the run.
- DONE: signature, count and pass hold; in_valid is ignored.
- DONE, start=1: re-seed as from IDLE, pass<=0, go to RUN. done falls on the next cycle.
- Simultaneous start and in_valid in IDLE/DONE: only the seed is loaded; that data word is not accepted.
- Arithmetic is pure XOR/shift mod 2; no carries. count never exceeds NUM_SAMPLES.
- Latency: final sample to done=1 is 1 cycle.

Test Plan:
- Reset mid-run: NUM_SAMPLES=10, assert rst after 4 samples -> same cycle: busy=0, done=0, count=0, signature=SEED; a later start begins a clean run.
- Single sample: NUM_SAMPLES=1, SEED=0, start, then data_in=20'h12345 with expected=20'h12345 -> next cycle done=1, pass=1, signature=20'h12345, count=1.
- Feedback tap: NUM_SAMPLES=2, SEED=0, samples 20'h80000 then 20'h00000, expected=20'h00009 -> done=1, pass=1, signature=20'h00009.
- Mismatch: same run as the feedback-tap case but expected=20'h00008 -> done=1, pass=0, signature=20'h00009.
- Gaps and ignored inputs: repeat the feedback-tap run with 3 idle cycles between samples, and pulse start during RUN -> identical result; count reads 1 during the gap.
- Restart from DONE: after a pass, start, then run 10 samples of 20'h00000 with SEED=0 -> signature=0, pass=1 if expected=0; pass was 0 during the run.
